// File: rtl/subneg_pkg.sv
// Shared widths, typedefs and constants for the SUBNEG one-instruction processor datapath.
package subneg_pkg;

    localparam int DEFAULT_DW    = 8;
    localparam int DEFAULT_DEPTH = 16;
    localparam int DEFAULT_AW    = $clog2(DEFAULT_DEPTH);

    typedef logic [DEFAULT_DW-1:0] word_t;
    typedef logic [DEFAULT_AW-1:0] addr_t;

    // Each instruction occupies three consecutive words: A, B, C.
    localparam int PC_STEP = 3;

endpackage

// File: rtl/subneg_mem.sv
// Program/data memory: register array with one write port and combinational read ports.
module subneg_mem #(
    parameter int DW    = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] addr_pc,
    input  logic [AW-1:0] addr_pc1,
    input  logic [AW-1:0] addr_pc2,
    input  logic [AW-1:0] addr_a,
    input  logic [AW-1:0] addr_b,
    input  logic [AW-1:0] addr_dbg,
    output logic [AW-1:0] ptr_pc,
    output logic [AW-1:0] ptr_pc1,
    output logic [AW-1:0] ptr_pc2,
    output logic [DW-1:0] data_a,
    output logic [DW-1:0] data_b,
    output logic [DW-1:0] dbg_data
);

    logic [DW-1:0] mem_q [DEPTH];

    // Contents are deliberately not reset so programs survive a processor reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Instruction words are only ever used as addresses, so only their low bits leave the array.
    always_comb begin
        ptr_pc   = mem_q[addr_pc][AW-1:0];
        ptr_pc1  = mem_q[addr_pc1][AW-1:0];
        ptr_pc2  = mem_q[addr_pc2][AW-1:0];
        data_a   = mem_q[addr_a];
        data_b   = mem_q[addr_b];
        dbg_data = mem_q[addr_dbg];
    end

endmodule

// File: rtl/subneg_datapath.sv
// SUBNEG datapath: OP1/OP2/PC registers, subtractor, next-PC mux and load-port priority.
module subneg_datapath
    import subneg_pkg::*;
#(
    parameter int DW    = DEFAULT_DW,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          write_op1,
    input  logic          write_op2,
    input  logic          write_mem,
    input  logic          sel_pc,
    input  logic          write_pc,
    output logic          neg,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [DW-1:0] load_data,
    output logic [DW-1:0] dbg_data,
    output logic [AW-1:0] pc
);

    logic [AW-1:0] pc_q, pc_d;
    logic [DW-1:0] op1_q, op1_d;
    logic [DW-1:0] op2_q, op2_d;

    logic [AW-1:0] pc_plus1, pc_plus2, pc_plus3;
    logic [AW-1:0] ptr_a, ptr_b, ptr_c;
    logic [DW-1:0] data_a, data_b;
    logic [DW-1:0] res;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;

    assign pc_plus1 = pc_q + AW'(1);
    assign pc_plus2 = pc_q + AW'(2);
    assign pc_plus3 = pc_q + AW'(PC_STEP);
    assign res      = op2_q - op1_q;
    assign neg      = res[DW-1];
    assign pc       = pc_q;

    // The external load port wins the single write port; reset blocks only the datapath write.
    always_comb begin
        mem_we    = load_en | (write_mem & ~rst);
        mem_waddr = ptr_b;
        mem_wdata = res;
        if (load_en) begin
            mem_waddr = load_addr;
            mem_wdata = load_data;
        end
    end

    subneg_mem #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk      (clk),
        .we       (mem_we),
        .waddr    (mem_waddr),
        .wdata    (mem_wdata),
        .addr_pc  (pc_q),
        .addr_pc1 (pc_plus1),
        .addr_pc2 (pc_plus2),
        .addr_a   (ptr_a),
        .addr_b   (ptr_b),
        .addr_dbg (load_addr),
        .ptr_pc   (ptr_a),
        .ptr_pc1  (ptr_b),
        .ptr_pc2  (ptr_c),
        .data_a   (data_a),
        .data_b   (data_b),
        .dbg_data (dbg_data)
    );

    always_comb begin
        op1_d = op1_q;
        op2_d = op2_q;
        pc_d  = pc_q;
        if (write_op1) begin
            op1_d = data_a;
        end
        if (write_op2) begin
            op2_d = data_b;
        end
        if (write_pc) begin
            pc_d = sel_pc ? ptr_c : pc_plus3;
        end
        if (rst) begin
            op1_d = '0;
            op2_d = '0;
            pc_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        op1_q <= op1_d;
        op2_q <= op2_d;
        pc_q  <= pc_d;
    end

endmodule

// File: tb/tb_subneg_datapath.sv
// Directed self-checking bench for subneg_datapath with hand-computed expectations.
module tb_subneg_datapath;

    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          write_op1 = 1'b0;
    logic          write_op2 = 1'b0;
    logic          write_mem = 1'b0;
    logic          sel_pc = 1'b0;
    logic          write_pc = 1'b0;
    logic          neg;
    logic          load_en = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [DW-1:0] load_data = '0;
    logic [DW-1:0] dbg_data;
    logic [AW-1:0] pc;

    int checks = 0;
    int failures = 0;

    subneg_datapath #(.DW(DW), .DEPTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .write_op1 (write_op1),
        .write_op2 (write_op2),
        .write_mem (write_mem),
        .sel_pc    (sel_pc),
        .write_pc  (write_pc),
        .neg       (neg),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .dbg_data  (dbg_data),
        .pc        (pc)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_strobes();
        rst = 0; write_op1 = 0; write_op2 = 0; write_mem = 0;
        write_pc = 0; sel_pc = 0; load_en = 0;
    endtask

    task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
        load_en = 1; load_addr = a; load_data = d;
        tick();
        load_en = 0;
    endtask

    task automatic peek(input logic [AW-1:0] a, output logic [DW-1:0] d);
        load_addr = a;
        #1;
        d = dbg_data;
    endtask

    task automatic do_reset();
        clear_strobes();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic pulse(input int which, input logic sel);
        case (which)
            1: write_op1 = 1;
            2: write_op2 = 1;
            3: write_mem = 1;
            default: begin write_pc = 1; sel_pc = sel; end
        endcase
        tick();
        clear_strobes();
    endtask

    task automatic load_program(input logic [DW-1:0] m8, input logic [DW-1:0] m9);
        poke(0, 8); poke(1, 9); poke(2, 6); poke(8, m8); poke(9, m9);
    endtask

    task automatic test_reset();
        logic [DW-1:0] d;
        poke(3, 8'hA5);
        do_reset();
        checks++;
        if (pc !== 4'd0) begin failures++; $display("[TB] FAIL reset_pc: got %0d expected 0", pc); end
        checks++;
        if (neg !== 1'b0) begin failures++; $display("[TB] FAIL reset_neg: got %0b expected 0", neg); end
        peek(3, d);
        checks++;
        if (d !== 8'hA5) begin failures++; $display("[TB] FAIL reset_keeps_mem: got %0h expected a5", d); end
    endtask

    task automatic test_nonneg_step();
        logic [DW-1:0] d;
        do_reset();
        load_program(3, 5);
        pulse(1, 0);
        checks++;
        if (dut.op1_q !== 8'd3) begin failures++; $display("[TB] FAIL nonneg_op1: got %0d expected 3", dut.op1_q); end
        pulse(2, 0);
        checks++;
        if (dut.op2_q !== 8'd5) begin failures++; $display("[TB] FAIL nonneg_op2: got %0d expected 5", dut.op2_q); end
        checks++;
        if (neg !== 1'b0) begin failures++; $display("[TB] FAIL nonneg_neg: got %0b expected 0", neg); end
        pulse(3, 0);
        peek(9, d);
        checks++;
        if (d !== 8'd2) begin failures++; $display("[TB] FAIL nonneg_mem9: got %0h expected 2", d); end
        pulse(4, 0);
        checks++;
        if (pc !== 4'd3) begin failures++; $display("[TB] FAIL nonneg_pc: got %0d expected 3", pc); end
    endtask

    task automatic test_negative_branch();
        logic [DW-1:0] d;
        do_reset();
        load_program(7, 5);
        pulse(1, 0);
        pulse(2, 0);
        checks++;
        if (neg !== 1'b1) begin failures++; $display("[TB] FAIL negbr_neg: got %0b expected 1", neg); end
        pulse(3, 0);
        peek(9, d);
        checks++;
        if (d !== 8'hFE) begin failures++; $display("[TB] FAIL negbr_mem9: got %0h expected fe", d); end
        pulse(4, 1);
        checks++;
        if (pc !== 4'd6) begin failures++; $display("[TB] FAIL negbr_pc: got %0d expected 6", pc); end
    endtask

    task automatic test_wrap_around();
        logic [DW-1:0] d;
        do_reset();
        poke(2, 14);
        pulse(4, 1);
        checks++;
        if (pc !== 4'd14) begin failures++; $display("[TB] FAIL wrap_jump14: got %0d expected 14", pc); end
        poke(14, 4); poke(15, 5); poke(0, 2); poke(4, 1); poke(5, 1);
        pulse(1, 0);
        pulse(2, 0);
        checks++;
        if (neg !== 1'b0) begin failures++; $display("[TB] FAIL wrap_neg: got %0b expected 0", neg); end
        pulse(3, 0);
        peek(5, d);
        checks++;
        if (d !== 8'd0) begin failures++; $display("[TB] FAIL wrap_mem5: got %0h expected 0", d); end
        pulse(4, 0);
        checks++;
        if (pc !== 4'd1) begin failures++; $display("[TB] FAIL wrap_pc_step: got %0d expected 1", pc); end
        do_reset();
        pulse(4, 1);
        pulse(4, 1);
        checks++;
        if (pc !== 4'd2) begin failures++; $display("[TB] FAIL wrap_pc_branch: got %0d expected 2", pc); end
    endtask

    task automatic test_load_priority();
        logic [DW-1:0] d;
        do_reset();
        load_program(3, 5);
        pulse(1, 0);
        pulse(2, 0);
        write_mem = 1; write_pc = 1; sel_pc = 0;
        load_en = 1; load_addr = 9; load_data = 8'h55;
        tick();
        clear_strobes();
        peek(9, d);
        checks++;
        if (d !== 8'h55) begin failures++; $display("[TB] FAIL loadprio_mem9: got %0h expected 55", d); end
        checks++;
        if (pc !== 4'd3) begin failures++; $display("[TB] FAIL loadprio_pc: got %0d expected 3", pc); end
    endtask

    task automatic test_reset_mid_instruction();
        logic [DW-1:0] d;
        do_reset();
        load_program(7, 5);
        pulse(1, 0);
        pulse(2, 0);
        checks++;
        if (neg !== 1'b1) begin failures++; $display("[TB] FAIL rstmid_neg_before: got %0b expected 1", neg); end
        rst = 1; write_mem = 1; write_pc = 1; sel_pc = 1;
        tick();
        clear_strobes();
        checks++;
        if (pc !== 4'd0) begin failures++; $display("[TB] FAIL rstmid_pc: got %0d expected 0", pc); end
        checks++;
        if (neg !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_neg: got %0b expected 0", neg); end
        peek(9, d);
        checks++;
        if (d !== 8'd5) begin failures++; $display("[TB] FAIL rstmid_mem9: got %0h expected 5", d); end
    endtask

    task automatic test_coincident_strobes();
        logic [DW-1:0] d;
        do_reset();
        load_program(3, 5);
        write_op1 = 1; write_op2 = 1;
        tick();
        clear_strobes();
        checks++;
        if (dut.op1_q !== 8'd3) begin failures++; $display("[TB] FAIL coinc_op1: got %0d expected 3", dut.op1_q); end
        checks++;
        if (dut.op2_q !== 8'd5) begin failures++; $display("[TB] FAIL coinc_op2: got %0d expected 5", dut.op2_q); end
        checks++;
        if (neg !== 1'b0) begin failures++; $display("[TB] FAIL coinc_neg_pos: got %0b expected 0", neg); end
        write_op2 = 1; write_mem = 1; write_pc = 1; sel_pc = 0;
        tick();
        clear_strobes();
        checks++;
        if (dut.op2_q !== 8'd5) begin failures++; $display("[TB] FAIL coinc_op2_preedge: got %0d expected 5", dut.op2_q); end
        peek(9, d);
        checks++;
        if (d !== 8'd2) begin failures++; $display("[TB] FAIL coinc_mem9: got %0h expected 2", d); end
        checks++;
        if (pc !== 4'd3) begin failures++; $display("[TB] FAIL coinc_pc: got %0d expected 3", pc); end
        do_reset();
        load_program(9, 5);
        write_op1 = 1; write_op2 = 1;
        tick();
        clear_strobes();
        checks++;
        if (neg !== 1'b1) begin failures++; $display("[TB] FAIL coinc_neg_neg: got %0b expected 1", neg); end
    endtask

    initial begin
        clear_strobes();
        tick();
        test_reset();
        test_nonneg_step();
        test_negative_branch();
        test_wrap_around();
        test_load_priority();
        test_reset_mid_instruction();
        test_coincident_strobes();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/subneg_datapath.md
# subneg_datapath

Datapath and program/data memory for the SUBNEG one-instruction processor, driven by the `control` FSM's five strobes and returning `neg` to it. Each instruction is three consecutive words A, B, C. The block subtracts `mem[mem[A]]` from `mem[mem[B]]` and writes the result back to `mem[mem[B]]`. It branches to C if the result is negative, otherwise it advances the PC by 3. A load/debug port lets benches preload programs and inspect memory.

## Interface
- `DW`, default 8: data word width (two's complement).
- `DEPTH`, default 16: memory words, power of two; `AW = $clog2(DEPTH)`.
- `clk`, input, 1: clock.
- `rst`, input, 1: synchronous, active-high reset.
- `write_op1`, input, 1: load OP1 register.
- `write_op2`, input, 1: load OP2 register.
- `write_mem`, input, 1: write subtraction result to memory.
- `sel_pc`, input, 1: next-PC select (1 = branch target, 0 = PC+3).
- `write_pc`, input, 1: load PC.
- `neg`, output, 1: sign of OP2−OP1, to control.
- `load_en`, input, 1: external memory write.
- `load_addr`, input, AW: external write/read address.
- `load_data`, input, DW: external write data.
- `dbg_data`, output, DW: combinational `mem[load_addr]`.
- `pc`, output, AW: current PC.

## Operation
- Address arithmetic:
  - All addresses are taken modulo DEPTH.
  - Indirect addresses use the low AW bits of the memory word.
  - PC+1, PC+2 and PC+3 wrap.
- Operand and result path:
  - `write_op1`: OP1 ← `mem[mem[PC]]`.
  - `write_op2`: OP2 ← `mem[mem[PC+1]]`.
  - RES = OP2 − OP1, DW-bit wrap-around; `neg` = RES[DW−1], combinational from the OP registers.
  - `write_mem`: `mem[mem[PC+1]]` ← RES.
- PC update, on `write_pc`:
  - `sel_pc`=1: PC ← `mem[PC+2]` low AW bits.
  - `sel_pc`=0: PC ← PC+3.
- Strobes are independent and may coincide; all right-hand sides use pre-edge values.
- `load_en`=1 has priority: `mem[load_addr]` ← `load_data`, and a simultaneous `write_mem` is suppressed. OP, PC and `neg` updates proceed normally.
- Reset:
  - PC=0, OP1=0, OP2=0, so `neg`=0.
  - Memory contents are not cleared.
  - `rst` overrides every strobe in the same cycle, except `load_en`, which still writes.

## Timing
- Memory: combinational reads, writes on the rising edge.
- The OP/PC register loaded by a strobe is visible the cycle after the strobe.
- `neg` is valid one cycle after the `write_op2` (or `write_op1`) edge. `control` samples it before asserting `write_pc`.
- A read in the cycle after `write_mem` returns the new value. There is no same-cycle bypass.
- Reset mid-instruction abandons it. Any memory write already committed on an earlier edge stays.
- `dbg_data` is combinational and reflects writes from the previous edge.

## Structure
- `subneg_pkg` holds:
  - `DW`/`DEPTH` defaults and `AW`;
  - `word_t` and `addr_t` typedefs;
  - `PC_STEP` = 3.
- Sub-module `subneg_mem`:
  - register array;
  - one write port, with the load-priority mux done in the parent;
  - read ports for PC, PC+1, PC+2, the two indirect addresses and debug.
- The parent `subneg_datapath` holds the OP1/OP2/PC registers, the subtractor and the next-PC mux.

## Test plan
- **Non-negative step.**
  - Stimulus: preload `mem[0..2]`={8,9,6}, `mem[8]`=3, `mem[9]`=5; pulse `write_op1`, `write_op2`, `write_mem`, then `write_pc` with `sel_pc`=0.
  - Response: OP1=3, OP2=5, `neg`=0, `mem[9]`=2, `pc`=3.
- **Negative branch.**
  - Stimulus: same program with `mem[8]`=7; `write_pc` with `sel_pc`=1.
  - Response: `neg`=1, `mem[9]`=0xFE, `pc`=6.
- **Wrap-around.**
  - Stimulus: PC=14, `mem[14]`=4, `mem[15]`=5, `mem[0]`=2, `mem[4]`=1, `mem[5]`=1; `sel_pc`=0.
  - Response: `mem[5]`=0, `neg`=0, `pc`=1. With `sel_pc`=1: `pc`=2.
- **Load priority.**
  - Stimulus: `write_mem` and `load_en` (addr 9, data 0x55) asserted in the same cycle.
  - Response: `mem[9]`=0x55, `dbg_data`=0x55.
- **Reset mid-instruction.**
  - Stimulus: `rst` after `write_op2` with `neg`=1.
  - Response: next cycle `pc`=0, `neg`=0; memory unchanged.
- **Coincident strobes.**
  - Stimulus: `write_op1` and `write_op2` in the same cycle.
  - Response: both registers load from pre-edge addresses; `neg` is correct the next cycle.
